regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port register file for the pipelined MIPS core, with one write port and an integrated pending-write scoreboard.
- Sits in decode: up to NREAD operands read per cycle, registered, with a per-operand "busy" flag so hazard logic can stall on in-flight producers.
- Writeback drives the write port; issue marks the destination register pending.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- rd_addr  in  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  registered read data, same packing.
- rd_busy  out  NREAD  registered pending-write flag per read port.
- we  in  1  write enable (writeback).
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- flush  in  1  pipeline flush; clears all busy bits.
- any_busy  out  1  registered OR of all busy bits.

Behaviour:
- Reset (rst low, asynchronous):
  - entry i <= i zero-extended to DATA_W; entry 0 <= 0 when ZERO_REG=1.
  - All busy bits <= 0; rd_data <= 0; rd_busy <= 0; any_busy <= 0.
- Write: on a clk edge with we=1, entry[wa] <= wd. Ignored when ZERO_REG=1 and wa=0.
- Read latency: 1 cycle. On each clk edge, rd_data[k] <= entry[rd_addr[k]], subject to the bypass rule under Optional Feature.
- Register 0 with ZERO_REG=1 always returns 0 and rd_busy=0.
- Busy update, per edge, in priority order:
  1. flush=1: all busy <= 0; iss_valid is ignored that cycle.
  2. Otherwise, we=1 clears busy[wa].
  3. Then iss_valid=1 sets busy[iss_addr].
  4. iss_valid and we to the same address in the same cycle leave busy set, because the new producer wins.
  5. iss_addr=0 with ZERO_REG=1 sets nothing.
- rd_busy[k] <= busy_next[rd_addr[k]], i.e. the value after this cycle's updates. A same-cycle writeback therefore shows not-busy, and a same-cycle issue shows busy.
- any_busy <= OR of busy_next.
- Multiple read ports may address the same register; each returns identical data and busy.
- Read/write address collision is governed by the optional feature only.
- Reset asserted mid-operation aborts everything immediately. Pending busy bits are lost, and the pipeline must be flushed by the same reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first. If we=1 and wa==rd_addr[k] (and the write is not to a suppressed register 0), rd_data[k] <= wd in the same edge.
- Undefined: read-before-write. rd_data[k] returns the old entry value; the new value is visible one cycle later.
- The scoreboard is identical in both builds.

Decomposition:
- Shared package regfile_pkg:
  - constants DATA_W_DEF=32, ADDR_W_DEF=5, NREAD_MAX=4;
  - typedef reg_addr_t (ADDR_W bits);
  - typedef reg_data_t (DATA_W bits).
- Sub-module regfile_scoreboard:
  - owns the busy vector, the flush/clear/set priority and busy_next;
  - exports busy_next so the top level registers rd_busy and any_busy.
- Storage array and read ports stay in the top level.

Test Plan:
1. Reset release, read ports at addresses 5 and 31 → after one edge, rd_data = 5 and 31; rd_busy = 0; any_busy = 0.
2. we=1, wa=7, wd=0xDEADBEEF; rd_addr[0]=7 in the same cycle:
   - with REGFILE_BYPASS_EN → next cycle rd_data[0] = 0xDEADBEEF;
   - without it → next cycle rd_data[0] = 7, and the cycle after = 0xDEADBEEF.
3. ZERO_REG=1, write 0x1234 to reg 0 and issue to reg 0 → reads of reg 0 return 0, rd_busy=0, any_busy=0.
4. iss_valid, iss_addr=9 → next read of reg 9 gives rd_busy=1. Then we to wa=9 with rd_addr=9 → rd_busy=0 in the following cycle.
5. iss_valid to 12 and we to 12 in the same cycle → busy[12] stays 1. Then flush=1 together with iss_valid to 3 → all busy 0, including reg 3; any_busy=0.
6. rst pulsed low mid-stream, between edges, with busy bits set → outputs go to 0 immediately without a clk edge; the entry at address 10 reads 10 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// REGFILE_BYPASS_EN selects write-first reads in regfile_mp_sb.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_MAX  = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy vector with flush > clear > set priority.
// busy_next is exported so the top can register per-port flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  output logic [(1<<ADDR_W)-1:0] busy_next
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    if (flush) begin
      w_busy_next = '0;
    end else begin
      if (we)
        w_busy_next[wa] = 1'b0;
      // Issue after clear: a new producer beats a retiring one.
      if (iss_valid)
        w_busy_next[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0)
      w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_next;
  end

  assign busy_next = w_busy_next;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with one write port and scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-before-write.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic                    any_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [NREAD*DATA_W-1:0] r_rd_data;
  logic [NREAD-1:0]        r_rd_busy;
  logic                    r_any_busy;

  logic [DEPTH-1:0]        w_busy_next;
  logic                    w_wr_en;
  logic [NREAD*DATA_W-1:0] w_rd_data;
  logic [NREAD-1:0]        w_rd_busy;
  logic [ADDR_W-1:0]       w_addr;

  assign w_wr_en = we && !((ZERO_REG != 0) && (wa == '0));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy_next (w_busy_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= DATA_W'(i);
    end else if (w_wr_en) begin
      r_mem[wa] <= wd;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_addr    = '0;
    for (int k = 0; k < NREAD; k++) begin
      w_addr = rd_addr[k*ADDR_W +: ADDR_W];
      w_rd_data[k*DATA_W +: DATA_W] = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (wa == w_addr))
        w_rd_data[k*DATA_W +: DATA_W] = wd;
`endif
      if ((ZERO_REG != 0) && (w_addr == '0))
        w_rd_data[k*DATA_W +: DATA_W] = '0;
      w_rd_busy[k] = w_busy_next[w_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_busy  <= '0;
      r_any_busy <= 1'b0;
    end else begin
      r_rd_data  <= w_rd_data;
      r_rd_busy  <= w_rd_busy;
      r_any_busy <= |w_busy_next;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_busy  = r_rd_busy;
  assign any_busy = r_any_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (default parameters).
// Honours REGFILE_BYPASS_EN for the write/read collision case.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        flush;
  logic        any_busy;

  int n_chk = 0;
  int n_err = 0;

  regfile_mp_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .any_busy  (any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0;
    iss_valid = 0; iss_addr = 0; flush = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd(0, 0);
    #1 rst = 1'b0;
    #1;
    chk("rst_data", rd_data[31:0], 32'h0);
    chk("rst_any", {31'h0, any_busy}, 32'h0);

    // 1: reset values
    @(negedge clk);
    rst = 1'b1;
    rd(5, 31);
    step();
    chk("t1_rd0", rd_data[31:0], 32'd5);
    chk("t1_rd1", rd_data[63:32], 32'd31);
    chk("t1_busy", {30'h0, rd_busy}, 32'h0);
    chk("t1_any", {31'h0, any_busy}, 32'h0);
    rd(31, 31);
    step();
    chk("t1_same0", rd_data[31:0], 32'd31);
    chk("t1_same1", rd_data[63:32], 32'd31);

    // 2: write/read collision
    we = 1; wa = 7; wd = 32'hDEADBEEF;
    rd(7, 5);
    step();
    idle();
`ifdef REGFILE_BYPASS_EN
    chk("t2_coll", rd_data[31:0], 32'hDEADBEEF);
`else
    chk("t2_coll", rd_data[31:0], 32'd7);
`endif
    step();
    chk("t2_after", rd_data[31:0], 32'hDEADBEEF);

    // 3: register 0
    we = 1; wa = 0; wd = 32'h1234;
    iss_valid = 1; iss_addr = 0;
    rd(0, 0);
    step();
    idle();
    chk("t3_rd0", rd_data[31:0], 32'h0);
    chk("t3_busy", {30'h0, rd_busy}, 32'h0);
    chk("t3_any", {31'h0, any_busy}, 32'h0);
    step();
    chk("t3_rd0b", rd_data[63:32], 32'h0);

    // 4: issue then writeback
    iss_valid = 1; iss_addr = 9;
    rd(9, 8);
    step();
    idle();
    chk("t4_busy", {30'h0, rd_busy}, 32'h1);
    chk("t4_any", {31'h0, any_busy}, 32'h1);
    step();
    chk("t4_hold", {30'h0, rd_busy}, 32'h1);
    we = 1; wa = 9; wd = 32'h99;
    step();
    idle();
    chk("t4_wb", {30'h0, rd_busy}, 32'h0);
    chk("t4_any0", {31'h0, any_busy}, 32'h0);

    // 5: issue+write same reg, then flush with issue
    iss_valid = 1; iss_addr = 12;
    we = 1; wa = 12; wd = 32'h55;
    rd(12, 3);
    step();
    idle();
    chk("t5_same", {30'h0, rd_busy}, 32'h1);
    step();
    chk("t5_keep", {30'h0, rd_busy}, 32'h1);
    chk("t5_data", rd_data[31:0], 32'h55);
    flush = 1; iss_valid = 1; iss_addr = 3;
    step();
    idle();
    chk("t5_flush", {30'h0, rd_busy}, 32'h0);
    chk("t5_any", {31'h0, any_busy}, 32'h0);

    // 6: async reset mid-stream
    we = 1; wa = 10; wd = 32'hAAAA;
    iss_valid = 1; iss_addr = 20;
    rd(10, 20);
    step();
    idle();
    step();
    chk("t6_pre", rd_data[31:0], 32'hAAAA);
    chk("t6_prebz", {30'h0, rd_busy}, 32'h2);
    chk("t6_preany", {31'h0, any_busy}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rd0", rd_data[31:0], 32'h0);
    chk("t6_rd1", rd_data[63:32], 32'h0);
    chk("t6_busy", {30'h0, rd_busy}, 32'h0);
    chk("t6_any", {31'h0, any_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("t6_ent10", rd_data[31:0], 32'd10);
    chk("t6_ent20", rd_data[63:32], 32'd20);
    chk("t6_bz", {30'h0, rd_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
